// File: rtl/uart_tx_tick.sv
// uart_tx_tick: tick-paced UART transmitter.
// Frame format: start bit, DATA_BITS data bits sent LSB first, an optional
// parity bit, then STOP_BITS stop bits. Each line level starts on the clock
// after a tick_i strobe. The upstream pulse period therefore sets the baud rate.
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous active-high reset
//   tick_i   one-clock bit-time strobe
//   data_i   word to send, sampled on valid_i && ready_o
//   valid_i  upstream word available
//   ready_o  word can be accepted (registered)
//   tx_o     serial line, idle high (registered)
//   busy_o   frame pending or in progress (registered)
module uart_tx_tick #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_tick: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_tick: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_tick: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] DATA_BITS_C = 4'(DATA_BITS);
  localparam logic [1:0] STOP_BITS_C = 2'(STOP_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // A tick in the acceptance cycle is ignored. The start bit waits for the next tick.
        if (valid_i && ready_q) begin
          shift_d = data_i;
          par_d   = 1'b0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (tick_i) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_i) begin
          tx_d      = shift_q[0];
          par_d     = par_q ^ shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 4'd1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick_i) begin
          if (bit_cnt_q < DATA_BITS_C) begin
            tx_d      = shift_q[0];
            par_d     = par_q ^ shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (PARITY != 0) begin
            // par_q holds the XOR of all data bits, which is the even-parity bit.
            tx_d    = (PARITY == 1) ? ~par_q : par_q;
            state_d = S_PARITY;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 2'd1;
            state_d    = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick_i) begin
          tx_d       = 1'b1;
          stop_cnt_d = 2'd1;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_i) begin
          if (stop_cnt_q < STOP_BITS_C) begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Handshake flags follow the next state. They change on the same edge as the state transition.
    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  assign ready_o = ready_q;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// tb_uart_tx_tick: directed self-checking bench for uart_tx_tick.
// Four instances cover the parameter sets under test: default 8N1, 7E1, 7O1 and 8N2.
// sel routes valid to one instance and picks the outputs that are observed.
// Inputs are driven on the falling edge. Outputs are sampled on the falling edge.
module tb_uart_tx_tick;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick = 1'b0;
  logic [8:0] data;
  logic       valid;
  logic [1:0] sel;
  int         tick_mode;   // 0 = no ticks, 1 = one tick every 10 clocks, 2 = tied high
  int         tcnt = 0;

  logic [3:0] rdy, txv, bsy;
  logic       tx_s, ready_s, busy_s;

  int n_pass  = 0;
  int n_total = 0;
  int waitc;

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tick_mode == 2) begin
      tick = 1'b1;
    end else if (tick_mode == 1) begin
      tick = (tcnt == 9);
      tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    end else begin
      tick = 1'b0;
    end
  end

  uart_tx_tick u_def (
    .clock(clock), .reset(reset), .tick_i(tick), .data_i(data[7:0]),
    .valid_i(valid && (sel == 2'd0)), .ready_o(rdy[0]), .tx_o(txv[0]), .busy_o(bsy[0]));

  uart_tx_tick #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_even (
    .clock(clock), .reset(reset), .tick_i(tick), .data_i(data[6:0]),
    .valid_i(valid && (sel == 2'd1)), .ready_o(rdy[1]), .tx_o(txv[1]), .busy_o(bsy[1]));

  uart_tx_tick #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clock(clock), .reset(reset), .tick_i(tick), .data_i(data[6:0]),
    .valid_i(valid && (sel == 2'd2)), .ready_o(rdy[2]), .tx_o(txv[2]), .busy_o(bsy[2]));

  uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clock(clock), .reset(reset), .tick_i(tick), .data_i(data[7:0]),
    .valid_i(valid && (sel == 2'd3)), .ready_o(rdy[3]), .tx_o(txv[3]), .busy_o(bsy[3]));

  assign tx_s    = txv[sel];
  assign ready_s = rdy[sel];
  assign busy_s  = bsy[sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Offers a word, waits (bounded) for ready, and returns on the falling edge after the handshake.
  task automatic send(input string tag, input logic [8:0] w);
    int guard = 0;
    data  = w;
    valid = 1'b1;
    while (ready_s !== 1'b1 && guard < 300) begin
      step();
      guard++;
    end
    chk({tag, "_ready_before_accept"}, ready_s, 1'b1);
    step();
    valid = 1'b0;
  endtask

  // Waits for the start-bit fall. Each frame bit must then hold for exactly per clocks.
  // ready_o is checked low for the whole frame and high right after it.
  task automatic measure(input string tag, input int nbits, input int per,
                         input logic [15:0] bits, output int wc);
    int bad_tx;
    int bad_rdy = 0;
    wc = 0;
    while (tx_s !== 1'b0 && wc < 400) begin
      step();
      wc++;
    end
    chk({tag, "_start_fall"}, tx_s, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      bad_tx = 0;
      for (int k = 0; k < per; k++) begin
        if (tx_s !== bits[i]) bad_tx++;
        if (ready_s !== 1'b0 || busy_s !== 1'b1) bad_rdy++;
        step();
      end
      chk($sformatf("%s_bit%0d_level_errors", tag, i), bad_tx, 0);
    end
    chk({tag, "_busy_during_frame_errors"}, bad_rdy, 0);
    chk({tag, "_ready_after_stop"}, ready_s, 1'b1);
    chk({tag, "_busy_after_stop"}, busy_s, 1'b0);
  endtask

  initial begin
    int e_tx, e_rdy, e_bsy;
    reset     = 1'b1;
    valid     = 1'b0;
    data      = '0;
    sel       = 2'd0;
    tick_mode = 1;

    // Reset state and idle behaviour.
    step();
    chk("reset_tx", tx_s, 1'b1);
    chk("reset_ready", ready_s, 1'b1);
    chk("reset_busy", busy_s, 1'b0);
    reset = 1'b0;
    e_tx = 0; e_rdy = 0; e_bsy = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx_s !== 1'b1) e_tx++;
      if (ready_s !== 1'b1) e_rdy++;
      if (busy_s !== 1'b0) e_bsy++;
    end
    chk("idle_tx_errors", e_tx, 0);
    chk("idle_ready_errors", e_rdy, 0);
    chk("idle_busy_errors", e_bsy, 0);
    chk("idle_all_ready", rdy, 4'hF);

    // 8N1, 0x55: frame 0,1,0,1,0,1,0,1,0,1.
    send("d55", 9'h055);
    chk("d55_ready_low_after_accept", ready_s, 1'b0);
    chk("d55_busy_after_accept", busy_s, 1'b1);
    measure("d55", 10, 10, 16'b0000_0010_1010_1010, waitc);

    // 7E1, 0x03: frame 0,1,1,0,0,0,0,0,0,1.
    sel = 2'd1;
    send("even03", 9'h003);
    measure("even03", 10, 10, 16'b0000_0010_0000_0110, waitc);

    // 7O1, 0x03: frame 0,1,1,0,0,0,0,0,1,1.
    sel = 2'd2;
    send("odd03", 9'h003);
    measure("odd03", 10, 10, 16'b0000_0011_0000_0110, waitc);

    // 8N2 with valid held high. data_i changes right after the first handshake.
    sel   = 2'd3;
    data  = 9'h0A0;
    valid = 1'b1;
    waitc = 0;
    while (ready_s !== 1'b1 && waitc < 300) begin
      step();
      waitc++;
    end
    step();
    chk("s2_first_accept_ready_low", ready_s, 1'b0);
    data = 9'h00F;
    // 0xA0: frame 0,0,0,0,0,0,1,0,1,1,1.
    measure("s2_a0", 11, 10, 16'b0000_0111_0100_0000, waitc);
    step();
    chk("s2_second_accept_ready_low", ready_s, 1'b0);
    valid = 1'b0;
    // 0x0F: frame 0,1,1,1,1,0,0,0,0,1,1. Start is on the next tick, 9 clocks from here.
    measure("s2_0f", 11, 10, 16'b0000_0110_0001_1110, waitc);
    chk("s2_gap_clocks_to_second_start", waitc, 9);

    // Reset in the middle of data bit 3 of 0xFF.
    sel = 2'd0;
    send("ff", 9'h0FF);
    waitc = 0;
    while (tx_s !== 1'b0 && waitc < 400) begin
      step();
      waitc++;
    end
    chk("ff_start_fall", tx_s, 1'b0);
    repeat (45) step();
    chk("ff_busy_mid_frame", busy_s, 1'b1);
    reset = 1'b1;
    #1;
    chk("ff_reset_tx_immediate", tx_s, 1'b1);
    chk("ff_reset_ready_immediate", ready_s, 1'b1);
    chk("ff_reset_busy_immediate", busy_s, 1'b0);
    step();
    reset = 1'b0;
    // 0x00: low for 9 bit times, then the stop bit.
    send("z00", 9'h000);
    measure("z00", 10, 10, 16'b0000_0010_0000_0000, waitc);

    // tick_i tied high, 0x81: frame 0,1,0,0,0,0,0,0,1,1 at one clock per bit.
    tick_mode = 2;
    repeat (2) step();
    send("t81", 9'h081);
    chk("t81_accept_tick_ignored_tx", tx_s, 1'b1);
    chk("t81_ready_low", ready_s, 1'b0);
    chk("t81_busy_high", busy_s, 1'b1);
    measure("t81", 10, 1, 16'b0000_0011_0000_0010, waitc);
    chk("t81_start_one_clock_after_accept", waitc, 1);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_tick.md
Name: uart_tx_tick

Overview:
- Serial UART transmitter that consumes a periodic single-cycle tick from the team's pulse generator, one tick per bit time.
- Accepts a parallel word over a valid/ready handshake.
- Shifts the word out LSB-first with a start bit, optional parity bit and stop bit(s).
- Line transitions are aligned to ticks, so baud rate is set entirely by the upstream pulse period.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
clock  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
tick_i  input  1  one-clock-wide bit-time strobe from the pulse generator.
data_i  input  DATA_BITS  word to transmit; sampled only on handshake.
valid_i  input  1  upstream has a word on data_i.
ready_o  output  1  block can accept a word; registered.
tx_o  output  1  serial line, idle high; registered.
busy_o  output  1  frame pending or in progress; registered.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - tx_o=1, ready_o=1, busy_o=0, state IDLE.
  - Shift register, bit counter and parity accumulator cleared; any partial frame is abandoned.
- States: IDLE, ARMED, START, DATA, PARITY, STOP.
- IDLE:
  - tx_o=1, ready_o=1.
  - Handshake when valid_i && ready_o at a rising edge: latch data_i into the shift register, clear the parity accumulator, go to ARMED.
  - Next clock: ready_o=0, busy_o=1.
  - A tick_i in the acceptance cycle is ignored.
- ARMED: tx_o stays 1. On the first tick_i: tx_o<=0, go to START.
- START: on tick_i, tx_o<=shift[0], parity accumulator ^= shift[0], shift right, bit counter=1, go to DATA.
- DATA: on tick_i:
  - If bit counter < DATA_BITS: emit the next bit the same way and increment the counter.
  - Else if PARITY!=0: tx_o<=parity bit, go to PARITY.
    - Even parity bit = XOR of the data bits.
    - Odd parity bit = its inverse.
  - Else: tx_o<=1, stop counter=1, go to STOP.
- PARITY: on tick_i, tx_o<=1, stop counter=1, go to STOP.
- STOP: on tick_i:
  - If stop counter < STOP_BITS: increment the counter.
  - Else: go to IDLE; ready_o=1 and busy_o=0 from the next clock.
  - tx_o remains 1 throughout.
- Timing:
  - Every line level changes exactly one clock after the tick_i cycle that caused it.
  - Each bit therefore lasts exactly one tick period.
  - Frame length = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS tick periods, measured from the start-bit falling edge.
- No back-to-back overlap: the earliest next handshake is the first clock after returning to IDLE, and that word's start bit begins on the following tick.
- valid_i while ready_o=0 is ignored. data_i changes after the handshake do not affect the frame.
- tick_i held high continuously: the block advances one bit per clock; this is legal and is used for fast simulation.
- tick_i never arriving: the block waits indefinitely in its current state, with no timeout.
- Illegal parameter values are caught with an elaboration-time error.

Test Plan:
- Reset, then idle 50 clocks with tick_i from a 10-clock pulse -> tx_o=1, ready_o=1, busy_o=0 throughout.
- Defaults, send 0x55 with a 10-clock tick -> tx_o sequence 0,1,0,1,0,1,0,1,0,1; each level held exactly 10 clocks; ready_o returns 1 one clock after the tick ending the stop bit.
- PARITY=2, DATA_BITS=7, send 0x03 -> frame 0,1,1,0,0,0,0,0,0,1 (even parity bit = 0). Repeat with PARITY=1 -> parity bit = 1.
- STOP_BITS=2, valid_i held high with 0xA0 then 0x0F -> second start bit begins no earlier than 2 full stop ticks after the last data bit; data_i changed mid-frame does not corrupt the first word.
- Assert reset during data bit 3 of 0xFF -> tx_o=1 and ready_o=1 immediately (same cycle). A subsequent 0x00 transmits a clean frame: 0 for 9 bit times, then 1.
- tick_i tied high, send 0x81 -> one bit per clock: 0,1,0,0,0,0,0,0,1,1. Tick coincident with the acceptance edge is ignored.
